// File: rtl/my_and_pkg.sv
// Shared constants and types for the my_and bitwise AND primitive.
// Optional statistics build: define MY_AND_STATS_EN.
package my_and_pkg;

    localparam int DEFAULT_WIDTH = 1;
    localparam int DEFAULT_CNT_W = 16;

    typedef logic [DEFAULT_CNT_W-1:0] cnt_t;

endpackage : my_and_pkg

// File: rtl/my_and_if.sv
// Operand/result bundle for my_and; hit_cnt/hit_sat exist only when
// MY_AND_STATS_EN is defined.
interface my_and_if #(
    parameter int WIDTH = my_and_pkg::DEFAULT_WIDTH
`ifdef MY_AND_STATS_EN
  , parameter int CNT_W = my_and_pkg::DEFAULT_CNT_W
`endif
);

    logic             en;
    logic [WIDTH-1:0] input1;
    logic [WIDTH-1:0] input2;
    logic [WIDTH-1:0] op;
    logic             op_all;
    logic [WIDTH-1:0] op_q;
    logic             op_all_q;
    logic             valid_q;
`ifdef MY_AND_STATS_EN
    logic [CNT_W-1:0] hit_cnt;
    logic             hit_sat;
`endif

    modport master (
        output en, input1, input2,
        input  op, op_all, op_q, op_all_q, valid_q
`ifdef MY_AND_STATS_EN
      , input  hit_cnt, hit_sat
`endif
    );

    modport slave (
        input  en, input1, input2,
        output op, op_all, op_q, op_all_q, valid_q
`ifdef MY_AND_STATS_EN
      , output hit_cnt, hit_sat
`endif
    );

endinterface : my_and_if

// File: rtl/my_and_sat_cnt.sv
// Saturating up-counter with synchronous active-high clear; holds at all-ones.
// Instantiated by my_and only when MY_AND_STATS_EN is defined.
module my_and_sat_cnt #(
    parameter int CNT_W = my_and_pkg::DEFAULT_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt,
    output logic             sat
);

    assign sat = &cnt;

    // NOTE: clocked state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement or block order.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (inc && !sat) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule : my_and_sat_cnt

// File: rtl/my_and.sv
// Bitwise two-input AND with combinational and registered results.
// Define MY_AND_STATS_EN to add the saturating hit counter (hit_cnt/hit_sat).
module my_and
    import my_and_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
`ifdef MY_AND_STATS_EN
  , parameter int CNT_W = DEFAULT_CNT_W
`endif
) (
    input  logic     clk,
    input  logic     rst,
    my_and_if.slave  bus
);

    logic [WIDTH-1:0] op_c;
    logic             op_all_c;
    logic [WIDTH-1:0] op_r;
    logic             op_all_r;
    logic             valid_r;

    // Combinational path stays live through reset and ignores en.
    assign op_c     = bus.input1 & bus.input2;
    assign op_all_c = &op_c;

    always_ff @(posedge clk) begin
        if (rst) begin
            op_r     <= '0;
            op_all_r <= 1'b0;
            valid_r  <= 1'b0;
        end else if (bus.en) begin
            op_r     <= op_c;
            op_all_r <= op_all_c;
            valid_r  <= 1'b1;
        end else begin
            valid_r  <= 1'b0;
        end
    end

    assign bus.op       = op_c;
    assign bus.op_all   = op_all_c;
    assign bus.op_q     = op_r;
    assign bus.op_all_q = op_all_r;
    assign bus.valid_q  = valid_r;

`ifdef MY_AND_STATS_EN
    my_and_sat_cnt #(
        .CNT_W (CNT_W)
    ) u_sat_cnt (
        .clk (clk),
        .rst (rst),
        .inc (bus.en & op_all_c),
        .cnt (bus.hit_cnt),
        .sat (bus.hit_sat)
    );
`endif

endmodule : my_and

// File: tb/tb_my_and.sv
// Self-checking bench for my_and: WIDTH=1 and WIDTH=8 instances on one clock,
// directed scenarios plus a randomized run against a behavioural model.
module tb_my_and;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    my_and_if #(.WIDTH(1)
`ifdef MY_AND_STATS_EN
      , .CNT_W(2)
`endif
    ) bus1 ();

    my_and_if #(.WIDTH(8)) bus8 ();

    my_and #(.WIDTH(1)
`ifdef MY_AND_STATS_EN
      , .CNT_W(2)
`endif
    ) u_w1 (
        .clk (clk),
        .rst (rst),
        .bus (bus1)
    );

    my_and #(.WIDTH(8)) u_w8 (
        .clk (clk),
        .rst (rst),
        .bus (bus8)
    );

    task automatic edge_wait();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus1.en = 1'b0; bus1.input1 = 1'b0; bus1.input2 = 1'b0;
        bus8.en = 1'b0; bus8.input1 = 8'h00; bus8.input2 = 8'h00;
        edge_wait();
        checks++;
        if (bus1.op_q !== 1'b0 || bus1.op_all_q !== 1'b0 || bus1.valid_q !== 1'b0) begin
            errors++;
            $display("FAIL reset_w1: op_q=%b op_all_q=%b valid_q=%b, want 0 0 0",
                     bus1.op_q, bus1.op_all_q, bus1.valid_q);
        end
        checks++;
        if (bus8.op_q !== 8'h00 || bus8.op_all_q !== 1'b0 || bus8.valid_q !== 1'b0) begin
            errors++;
            $display("FAIL reset_w8: op_q=%h op_all_q=%b valid_q=%b, want 00 0 0",
                     bus8.op_q, bus8.op_all_q, bus8.valid_q);
        end
`ifdef MY_AND_STATS_EN
        checks++;
        if (bus1.hit_cnt !== 2'd0 || bus1.hit_sat !== 1'b0) begin
            errors++;
            $display("FAIL reset_stats: hit_cnt=%0d hit_sat=%b, want 0 0", bus1.hit_cnt, bus1.hit_sat);
        end
`endif
        rst = 1'b0;
    endtask

    task automatic test_comb_w1();
        logic a_tab [4];
        logic b_tab [4];
        logic exp_tab [4];
        a_tab   = '{1'b0, 1'b1, 1'b0, 1'b1};
        b_tab   = '{1'b0, 1'b0, 1'b1, 1'b1};
        exp_tab = '{1'b0, 1'b0, 1'b0, 1'b1};
        for (int i = 0; i < 4; i++) begin
            bus1.input1 = a_tab[i];
            bus1.input2 = b_tab[i];
            #1;
            checks++;
            if (bus1.op !== exp_tab[i] || bus1.op_all !== exp_tab[i]) begin
                errors++;
                $display("FAIL comb_w1[%0d]: op=%b op_all=%b, want %b", i, bus1.op, bus1.op_all, exp_tab[i]);
            end
        end
    endtask

    task automatic test_capture_w1();
        bus1.en = 1'b1; bus1.input1 = 1'b1; bus1.input2 = 1'b1;
        edge_wait();
        checks++;
        if (bus1.op_q !== 1'b1 || bus1.op_all_q !== 1'b1 || bus1.valid_q !== 1'b1) begin
            errors++;
            $display("FAIL capture_w1: op_q=%b op_all_q=%b valid_q=%b, want 1 1 1",
                     bus1.op_q, bus1.op_all_q, bus1.valid_q);
        end
        bus1.en = 1'b0; bus1.input1 = 1'b0;
        edge_wait();
        checks++;
        if (bus1.op_q !== 1'b1 || bus1.op_all_q !== 1'b1 || bus1.valid_q !== 1'b0) begin
            errors++;
            $display("FAIL hold_w1: op_q=%b op_all_q=%b valid_q=%b, want 1 1 0",
                     bus1.op_q, bus1.op_all_q, bus1.valid_q);
        end
    endtask

    task automatic test_reset_priority();
        bus1.en = 1'b1; bus1.input1 = 1'b1; bus1.input2 = 1'b1;
        rst = 1'b1;
        edge_wait();
        checks++;
        if (bus1.op_q !== 1'b0 || bus1.op_all_q !== 1'b0 || bus1.valid_q !== 1'b0) begin
            errors++;
            $display("FAIL rst_priority: op_q=%b op_all_q=%b valid_q=%b, want 0 0 0",
                     bus1.op_q, bus1.op_all_q, bus1.valid_q);
        end
        checks++;
        if (bus1.op !== 1'b1) begin
            errors++;
            $display("FAIL rst_comb_live: op=%b, want 1", bus1.op);
        end
        rst = 1'b0;
        bus1.en = 1'b0;
    endtask

    task automatic test_comb_w8();
        bus8.input1 = 8'hF0; bus8.input2 = 8'h3C;
        #1;
        checks++;
        if (bus8.op !== 8'h30 || bus8.op_all !== 1'b0) begin
            errors++;
            $display("FAIL comb_w8_mixed: op=%h op_all=%b, want 30 0", bus8.op, bus8.op_all);
        end
        bus8.input1 = 8'hFF; bus8.input2 = 8'hFF;
        #1;
        checks++;
        if (bus8.op !== 8'hFF || bus8.op_all !== 1'b1) begin
            errors++;
            $display("FAIL comb_w8_ones: op=%h op_all=%b, want ff 1", bus8.op, bus8.op_all);
        end
    endtask

`ifdef MY_AND_STATS_EN
    task automatic test_stats_saturate();
        int exp_cnt [5];
        exp_cnt = '{1, 2, 3, 3, 3};
        rst = 1'b1;
        edge_wait();
        rst = 1'b0;
        bus1.en = 1'b1; bus1.input1 = 1'b1; bus1.input2 = 1'b1;
        for (int i = 0; i < 5; i++) begin
            edge_wait();
            checks++;
            if (bus1.hit_cnt !== 2'(exp_cnt[i]) || bus1.hit_sat !== (i >= 2)) begin
                errors++;
                $display("FAIL stats_edge%0d: hit_cnt=%0d hit_sat=%b, want %0d %b",
                         i + 1, bus1.hit_cnt, bus1.hit_sat, exp_cnt[i], (i >= 2));
            end
        end
        rst = 1'b1;
        edge_wait();
        checks++;
        if (bus1.hit_cnt !== 2'd0 || bus1.hit_sat !== 1'b0) begin
            errors++;
            $display("FAIL stats_clear: hit_cnt=%0d hit_sat=%b, want 0 0", bus1.hit_cnt, bus1.hit_sat);
        end
        rst = 1'b0;
        bus1.en = 1'b0;
    endtask
`endif

    task automatic test_random();
        logic [7:0]  q8;
        logic        all8_q;
        logic        v8;
        logic [15:0] cnt8;
        logic        q1;
        logic        all1_q;
        logic        v1;
        int          cnt1;
        logic [7:0]  a8, b8;
        logic        a1, b1, en8, en1, r;
        int          bad;

        rst = 1'b1;
        bus1.en = 1'b0; bus8.en = 1'b0;
        edge_wait();
        rst = 1'b0;
        q8 = '0; all8_q = 0; v8 = 0; cnt8 = '0;
        q1 = 0;  all1_q = 0; v1 = 0; cnt1 = 0;

        for (int n = 0; n < 300; n++) begin
            r   = ($urandom_range(0, 19) == 0);
            en8 = $urandom_range(0, 1) == 1;
            en1 = $urandom_range(0, 1) == 1;
            // Bias toward all-ones so op_all and the hit counter get exercised.
            a8  = ($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom);
            b8  = ($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom);
            a1  = 1'($urandom);
            b1  = 1'($urandom);
            rst = r;
            bus8.en = en8; bus8.input1 = a8; bus8.input2 = b8;
            bus1.en = en1; bus1.input1 = a1; bus1.input2 = b1;
            #1;
            checks++;
            if (bus8.op !== (a8 & b8) || bus8.op_all !== ((a8 & b8) == 8'hFF)) begin
                errors++;
                $display("FAIL rand_comb_w8[%0d]: op=%h op_all=%b, want %h %b",
                         n, bus8.op, bus8.op_all, a8 & b8, ((a8 & b8) == 8'hFF));
            end
            checks++;
            if (bus1.op !== (a1 && b1)) begin
                errors++;
                $display("FAIL rand_comb_w1[%0d]: op=%b, want %b", n, bus1.op, (a1 && b1));
            end

            if (r) begin
                q8 = '0; all8_q = 0; v8 = 0; cnt8 = '0;
                q1 = 0;  all1_q = 0; v1 = 0; cnt1 = 0;
            end else begin
                v8 = en8;
                if (en8) begin
                    q8 = a8 & b8;
                    all8_q = (q8 == 8'hFF);
                    if (all8_q && cnt8 != 16'hFFFF) cnt8 = cnt8 + 16'd1;
                end
                v1 = en1;
                if (en1) begin
                    q1 = a1 && b1;
                    all1_q = q1;
                    if (q1 && cnt1 < 3) cnt1 = cnt1 + 1;
                end
            end

            edge_wait();
            checks++;
            if (bus8.op_q !== q8 || bus8.op_all_q !== all8_q || bus8.valid_q !== v8) begin
                errors++;
                $display("FAIL rand_reg_w8[%0d]: op_q=%h op_all_q=%b valid_q=%b, want %h %b %b",
                         n, bus8.op_q, bus8.op_all_q, bus8.valid_q, q8, all8_q, v8);
            end
            checks++;
            if (bus1.op_q !== q1 || bus1.op_all_q !== all1_q || bus1.valid_q !== v1) begin
                errors++;
                $display("FAIL rand_reg_w1[%0d]: op_q=%b op_all_q=%b valid_q=%b, want %b %b %b",
                         n, bus1.op_q, bus1.op_all_q, bus1.valid_q, q1, all1_q, v1);
            end
`ifdef MY_AND_STATS_EN
            bad = 0;
            if (bus8.hit_cnt !== cnt8 || bus8.hit_sat !== (cnt8 == 16'hFFFF)) bad = 1;
            if (bus1.hit_cnt !== 2'(cnt1) || bus1.hit_sat !== (cnt1 == 3)) bad = 1;
            checks++;
            if (bad != 0) begin
                errors++;
                $display("FAIL rand_stats[%0d]: w8 cnt=%0d sat=%b want %0d; w1 cnt=%0d sat=%b want %0d",
                         n, bus8.hit_cnt, bus8.hit_sat, cnt8, bus1.hit_cnt, bus1.hit_sat, cnt1);
            end
`else
            bad = 0;
`endif
        end
        rst = 1'b0;
        bus1.en = 1'b0; bus8.en = 1'b0;
    endtask

    initial begin
        test_reset();
        test_comb_w1();
        test_capture_w1();
        test_reset_priority();
        test_comb_w8();
`ifdef MY_AND_STATS_EN
        test_stats_saturate();
`endif
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_my_and

// File: doc/my_and.md
Name: my_and

Overview:
- Parameterizable bitwise two-input AND gate, used as a basic logic primitive in lab datapaths.
- Provides a purely combinational result `op`, so existing time-delay-based checks need no clock.
- Also provides a registered copy with an enable and a valid flag, plus a reduction-AND flag.
- Sits at leaf level; instantiated directly by higher-level logic or benches.

Parameters:
- WIDTH, 1, bit width of input1, input2, op and op_q.
- CNT_W, 16, width of the optional saturating statistics counter.

Ports:
- clk  input  1  rising-edge clock for all registered outputs.
- rst  input  1  synchronous active-high reset.
- en  input  1  capture enable for the registered stage.
- input1  input  WIDTH  operand A.
- input2  input  WIDTH  operand B.
- op  output  WIDTH  combinational input1 & input2.
- op_all  output  1  combinational reduction AND of op (1 only when every bit of op is 1).
- op_q  output  WIDTH  registered op.
- op_all_q  output  1  registered op_all.
- valid_q  output  1  high for exactly the cycle after a capture.

Behaviour:
- Interface: one clock, clk; reset rst is synchronous and active-high. Polarity and synchronicity are fixed.
- Combinational path:
  - op = input1 & input2, bitwise, zero latency, no dependence on clk, rst or en.
  - op_all = &op.
  - Both combinational outputs must settle within the same delta/time step as an input change.
  - X/Z inputs propagate per standard bitwise AND semantics; no X-masking is performed.
- Registered path, evaluated at each rising clk edge:
  - If rst = 1: op_q <= 0, op_all_q <= 0, valid_q <= 0. Reset has priority over en.
  - Else if en = 1: op_q <= op, op_all_q <= op_all, valid_q <= 1.
  - Else: op_q and op_all_q hold their values; valid_q <= 0.
- Latency: one cycle from input sample to op_q.
- valid_q is a single-cycle pulse per capture; it stays high continuously when en is held high.
- Reset asserted mid-operation clears the registered outputs on the next edge. The combinational op remains live during reset.
- WIDTH = 1 must behave exactly as a plain 2-input AND gate.

Optional Feature:
- Macro: MY_AND_STATS_EN.
- When defined:
  - Adds output `hit_cnt` [CNT_W-1:0], a counter of clk edges where en = 1 and op_all = 1.
  - Increments by 1 per such edge and saturates at all-ones; it does not wrap.
  - Cleared to 0 by rst.
  - Adds output `hit_sat` (1 bit), high while hit_cnt is at all-ones.
- When undefined: neither port exists and no counter logic is generated. All other behaviour is identical.

Decomposition:
- Shared package my_and_pkg holds:
  - the default WIDTH and CNT_W constants;
  - a typedef for the CNT_W counter type.
- One natural sub-module: my_and_sat_cnt, the saturating counter instantiated only under MY_AND_STATS_EN.
- The AND logic and register stage stay in my_and.

Test Plan:
- WIDTH=1, drive input1/input2 = 0/0, 1/0, 0/1, 1/1 each held 1 time unit, no clock -> op = 0, 0, 0, 1 respectively, checked 1 unit after each change.
- WIDTH=1, en=1, input1=input2=1, one clk edge -> op_q=1, op_all_q=1, valid_q=1. Next edge with en=0 -> op_q holds 1, valid_q=0.
- rst=1 while en=1 and input1=input2=1 -> after the edge op_q=0, op_all_q=0, valid_q=0; op stays 1 combinationally.
- WIDTH=8, input1=8'hF0, input2=8'h3C -> op=8'h30, op_all=0. Then input1=input2=8'hFF -> op_all=1.
- MY_AND_STATS_EN, CNT_W=2, en=1, inputs all ones for 5 edges -> hit_cnt = 1, 2, 3, 3, 3; hit_sat rises on the third edge; rst clears both to 0.
